// File: rtl/data_access_hs.sv
// data_access_hs: MEM-stage load/store unit with a req/ack handshake to variable-latency memory.
// Define DATA_ACCESS_TIMEOUT_EN to add a BUSY watchdog that raises bus_err after TIMEOUT cycles.
module data_access_hs #(
  parameter int B       = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [5:0]        opcode,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [B-1:0]      write_data,
  input  logic              zero,
  input  logic              branch_in,
  input  logic              branchNot_in,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [B-1:0]      mem_wdata,
  input  logic [B-1:0]      mem_rdata,
  input  logic              mem_ack,
  output logic [B-1:0]      data_out,
  output logic              stall_out,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              pcSrc_out
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [B-1:0] wd_q, load_v;
  logic wr_q, req, mis, start, expire;
  logic [3:0] we_l;
  logic [7:0] byte_l;
  logic [15:0] half_l;
  // opcode[1] set means word access, otherwise opcode[0] selects half over byte
  assign req = op_valid && (mem_read || mem_write) && state == IDLE;
  assign mis = opcode[1] ? addr_in[1:0] != 2'b00 : opcode[0] && addr_in[0];
  assign start = req && !mis;
  assign we_l = !wr_q ? 4'b0000 : op_q[1] ? 4'b1111 : op_q[0] ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_q[1:0];
  assign mem_wdata = op_q[1] ? wd_q : op_q[0] ? {2{wd_q[15:0]}} : {4{wd_q[7:0]}};
  assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign byte_l = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_l = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign load_v = op_q[1] ? mem_rdata : op_q[0] ? {{16{!op_q[2] && half_l[15]}}, half_l} : {{24{!op_q[2] && byte_l[7]}}, byte_l};
  assign pcSrc_out = (branch_in && zero) || (branchNot_in && !zero);
`ifdef DATA_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || state != BUSY) ? '0 : cnt + 1'b1;
  assign expire = state == BUSY && !mem_ack && cnt == CW'(TIMEOUT - 1);
`else
  assign expire = 1'b0;
`endif
  assign bus_err = expire;
  always_comb begin
    state_n = (state == IDLE && start) ? BUSY : (state == BUSY && (mem_ack || expire)) ? DONE : (state == DONE) ? IDLE : state;
    mem_req = state == BUSY;
    stall_out = start || state == BUSY;
    mem_we = state == BUSY ? we_l : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      data_out <= '0;
      misalign_err <= 1'b0;
      op_q <= '0;
      addr_q <= '0;
      wd_q <= '0;
      wr_q <= 1'b0;
    end else begin
      state <= state_n;
      misalign_err <= req && mis;
      if (start) begin
        op_q <= opcode[2:0];
        addr_q <= addr_in;
        wd_q <= write_data;
        wr_q <= mem_write;
      end
      if (state == BUSY && mem_ack && !wr_q) data_out <= load_v;
    end
  end
endmodule

// File: tb/tb_data_access_hs.sv
// tb_data_access_hs: randomized scoreboard bench for data_access_hs with a behavioural access model.
module tb_data_access_hs;
  logic clk = 0, reset = 1, op_valid = 0, mem_write = 0, mem_read = 0, mem_ack = 0;
  logic zero = 0, branch_in = 0, branchNot_in = 0;
  logic [5:0] opcode = 0;
  logic [31:0] addr_in = 0, write_data = 0, mem_rdata = 0;
  logic mem_req, stall_out, misalign_err, bus_err, pcSrc_out;
  logic [3:0] mem_we;
  logic [31:0] mem_addr, mem_wdata, data_out;
  int checks = 0, failures = 0;
  typedef struct {
    bit mis;
    bit wr;
    logic [31:0] addr, wdata, dout;
    logic [3:0] we;
    int lat;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  bit pend = 0, prev_req = 0;
  int stall_cnt = 0;
  logic [31:0] model_dout = 0;

  always #5 clk = ~clk;

  data_access_hs dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .opcode(opcode), .mem_write(mem_write),
    .mem_read(mem_read), .addr_in(addr_in), .write_data(write_data), .zero(zero),
    .branch_in(branch_in), .branchNot_in(branchNot_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .data_out(data_out), .stall_out(stall_out), .misalign_err(misalign_err), .bus_err(bus_err),
    .pcSrc_out(pcSrc_out)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", n, act, want);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected access when a request starts or a misalign pulse appears
  always @(negedge clk) begin
    exp_t m;
    if (reset) begin
      pend = 0;
      prev_req = 0;
      stall_cnt = 0;
    end else begin
      if (stall_out) stall_cnt++;
      if (mem_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: got addr %h with nothing expected", mem_addr);
        end else begin
          cur = exp_q.pop_front();
          chk("req_not_misaligned", {31'b0, cur.mis}, 32'd0);
          chk("mem_addr", mem_addr, cur.addr);
          if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
          pend = 1;
        end
      end
      if (mem_req && pend) chk("mem_we", {28'b0, mem_we}, {28'b0, cur.we});
      if (!mem_req && prev_req && pend) begin
        chk("data_out", data_out, cur.dout);
        chk("stall_release", {31'b0, stall_out}, 32'd0);
        chk("stall_cycles", stall_cnt, cur.lat + 1);
        stall_cnt = 0;
        pend = 0;
      end
      if (misalign_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_misalign: got pulse with nothing expected");
        end else begin
          m = exp_q.pop_front();
          chk("misalign_expected", {31'b0, m.mis}, 32'd1);
          chk("misalign_no_stall", stall_cnt, 0);
          chk("misalign_no_req", {31'b0, mem_req}, 32'd0);
          chk("misalign_dout", data_out, m.dout);
        end
      end
      prev_req = mem_req;
    end
  end

  task automatic do_access(input logic [5:0] op, input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata, input int lat);
    exp_t e;
    int sz, sh, n;
    logic [31:0] v;
    sz = op[1] ? 4 : op[0] ? 2 : 1;
    sh = int'(addr[1:0]);
    e.mis = (addr % sz) != 0;
    e.wr = wr;
    e.addr = addr & ~32'h3;
    e.lat = lat;
    e.we = !wr ? 4'h0 : sz == 4 ? 4'hF : sz == 2 ? 4'(3 << sh) : 4'(1 << sh);
    e.wdata = sz == 4 ? wd : sz == 2 ? (wd & 32'hFFFF) * 32'h10001 : (wd & 32'hFF) * 32'h01010101;
    if (!wr && !e.mis) begin
      v = rdata >> (8 * sh);
      if (sz == 1) begin
        v &= 32'hFF;
        if (!op[2] && v >= 128) v -= 256;
      end else if (sz == 2) begin
        v &= 32'hFFFF;
        if (!op[2] && v >= 32768) v -= 65536;
      end
      model_dout = v;
    end
    e.dout = model_dout;
    exp_q.push_back(e);
    opcode = op; mem_write = wr; mem_read = rd; addr_in = addr; write_data = wd; op_valid = 1;
    if (e.mis) begin
      step;
      op_valid = 0; mem_write = 0; mem_read = 0;
      step;
      return;
    end
    step;
    n = 0;
    while (!mem_req && n < 8) begin
      step;
      n++;
    end
    if (!mem_req) begin
      chk("req_timeout", {31'b0, mem_req}, 32'd1);
      op_valid = 0; mem_write = 0; mem_read = 0;
      return;
    end
    repeat (lat - 1) step;
    mem_ack = 1; mem_rdata = rdata;
    step;
    mem_ack = 0; mem_rdata = $urandom;
    step;
    op_valid = 0; mem_write = 0; mem_read = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (2) step;
    reset = 0;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {28'b0, mem_we}, 32'd0);
    chk("rst_dout", data_out, 32'd0);
    chk("rst_mis", {31'b0, misalign_err}, 32'd0);
    chk("rst_bus", {31'b0, bus_err}, 32'd0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    branch_in = 1; branchNot_in = 0; zero = 1; #1;
    chk("beq_taken", {31'b0, pcSrc_out}, 32'd1);
    branch_in = 0; branchNot_in = 1; zero = 0; #1;
    chk("bne_taken", {31'b0, pcSrc_out}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      branch_in = 1'($urandom); branchNot_in = 1'($urandom); zero = 1'($urandom); #1;
      chk("pcsrc_rand", {31'b0, pcSrc_out}, {31'b0, (branch_in && zero) || (branchNot_in && !zero)});
    end
    branch_in = 0; branchNot_in = 0;
    step;
    do_access(6'h23, 0, 1, 32'h10, 0, 32'hDEADBEEF, 3);
    do_access(6'h20, 0, 1, 32'h13, 0, 32'h80AABBCC, 1);
    do_access(6'h24, 0, 1, 32'h13, 0, 32'h80AABBCC, 2);
    do_access(6'h21, 0, 1, 32'h12, 0, 32'h80AABBCC, 1);
    do_access(6'h25, 0, 1, 32'h12, 0, 32'h80AABBCC, 4);
    do_access(6'h28, 1, 0, 32'h21, 32'h123456A5, 0, 2);
    do_access(6'h29, 1, 0, 32'h22, 32'h123456A5, 0, 1);
    do_access(6'h2B, 1, 1, 32'h24, 32'h123456A5, 0, 3);
    do_access(6'h23, 0, 1, 32'h06, 0, 0, 1);
    do_access(6'h21, 0, 1, 32'h03, 0, 0, 1);
    // reset while a store is in flight, then a stray ack
    e = '{mis: 0, wr: 1, addr: 32'h40, wdata: 32'h11223344, dout: model_dout, we: 4'hF, lat: 0};
    exp_q.push_back(e);
    opcode = 6'h2B; mem_write = 1; mem_read = 0; addr_in = 32'h40; write_data = 32'h11223344; op_valid = 1;
    step;
    step;
    reset = 1; op_valid = 0; mem_write = 0;
    step;
    chk("rst_busy_req", {31'b0, mem_req}, 32'd0);
    chk("rst_busy_stall", {31'b0, stall_out}, 32'd0);
    reset = 0; model_dout = 0;
    step;
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    step;
    mem_ack = 0;
    step;
    chk("late_ack_req", {31'b0, mem_req}, 32'd0);
    chk("late_ack_stall", {31'b0, stall_out}, 32'd0);
    chk("late_ack_dout", data_out, model_dout);
    // memory that never answers
    e = '{mis: 0, wr: 0, addr: 32'h80, wdata: 32'h0, dout: model_dout, we: 4'h0, lat: 16};
    exp_q.push_back(e);
    opcode = 6'h23; mem_read = 1; mem_write = 0; addr_in = 32'h80; op_valid = 1;
    step;
`ifdef DATA_ACCESS_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      chk("bus_err_wait", {31'b0, bus_err}, {31'b0, k == 16});
      chk("req_wait", {31'b0, mem_req}, 32'd1);
      step;
    end
    chk("bus_err_pulse_end", {31'b0, bus_err}, 32'd0);
    chk("req_after_timeout", {31'b0, mem_req}, 32'd0);
    step;
    op_valid = 0; mem_read = 0;
`else
    repeat (100) step;
    chk("still_stalled", {31'b0, stall_out}, 32'd1);
    chk("still_req", {31'b0, mem_req}, 32'd1);
    chk("no_bus_err", {31'b0, bus_err}, 32'd0);
    reset = 1; op_valid = 0; mem_read = 0;
    step;
    reset = 0; model_dout = 0;
    step;
`endif
    for (int i = 0; i < 40; i++) begin
      logic [1:0] s;
      logic [31:0] a;
      bit w, r, u;
      int sz;
      s = $urandom_range(0, 2) == 2 ? 2'b11 : 2'($urandom_range(0, 1));
      sz = s == 2'b11 ? 4 : s == 2'b01 ? 2 : 1;
      w = 1'($urandom_range(0, 1));
      r = !w || $urandom_range(0, 3) == 0;
      u = !w && $urandom_range(0, 1) == 1;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'(sz - 1);
      do_access({2'b10, w, u, s}, w, r, a, $urandom, $urandom, $urandom_range(1, 4));
    end
    repeat (5) step;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
